// File: rtl/aes128_pkg.sv
// Shared AES-128 definitions: FSM states, round count, S-box table, rcon and byte-order helpers.
package aes128_pkg;

    typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

    localparam int unsigned NR = 10;

    // FIPS-197 forward S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round constant for rounds 1..10; anything else yields zero.
    function automatic logic [7:0] rcon_lut(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Byte 0 sits at [127:120]; returns the LSB position of byte idx.
    function automatic int unsigned byte_lsb(input int unsigned idx);
        return 120 - 8 * idx;
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes128_key_step.sv
// One step of the AES-128 key schedule, computed on the fly from the previous round key.
module aes128_key_step (
    input  logic [127:0] rk_in,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_out
);
    logic [31:0] w0, w1, w2, w3, rot, sub, t, n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = rk_in;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sub
        aes128_sbox u_sbox (
            .data_i(rot[8*i +: 8]),
            .data_o(sub[8*i +: 8])
        );
    end

    assign t  = sub ^ {rcon, 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign rk_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_mix_columns.sv
// MixColumns: each column multiplied by the fixed {02,03,01,01} circulant.
module aes128_mix_columns (
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);
    import aes128_pkg::*;

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = data_i[byte_lsb(4 * c)     +: 8];
        assign a1 = data_i[byte_lsb(4 * c + 1) +: 8];
        assign a2 = data_i[byte_lsb(4 * c + 2) +: 8];
        assign a3 = data_i[byte_lsb(4 * c + 3) +: 8];
        assign data_o[byte_lsb(4 * c)     +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign data_o[byte_lsb(4 * c + 1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign data_o[byte_lsb(4 * c + 2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign data_o[byte_lsb(4 * c + 3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

endmodule

// File: rtl/aes128_sbox.sv
// Single-byte forward S-box lookup.
module aes128_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);
    import aes128_pkg::*;

    assign data_o = SBOX[data_i];

endmodule

// File: rtl/aes128_shift_rows.sv
// ShiftRows: row r rotates left by r columns.
module aes128_shift_rows (
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);
    import aes128_pkg::*;

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign data_o[byte_lsb(r + 4 * c) +: 8] =
                data_i[byte_lsb(r + 4 * ((c + r) % 4)) +: 8];
        end
    end

endmodule

// File: rtl/aes128_sub_bytes.sv
// SubBytes: sixteen parallel S-box lookups.
module aes128_sub_bytes (
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);
    for (genvar i = 0; i < 16; i++) begin : g_byte
        aes128_sbox u_sbox (
            .data_i(data_i[8*i +: 8]),
            .data_o(data_o[8*i +: 8])
        );
    end

endmodule

// File: rtl/aes128_enc_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, valid/ready on both sides.
module aes128_enc_ctrl #(
    parameter int unsigned NR = aes128_pkg::NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_pt,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_ct,
    output logic         busy
);
    import aes128_pkg::*;

    state_e       state_q, state_d;
    logic [127:0] st_q, st_d, rk_q, rk_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] sb_out, sr_out, mc_out, rk_n;
    logic [7:0]   rcon_cur;
    logic         last_rnd;

    assign rcon_cur = rcon_lut(rnd_q);
    assign last_rnd = (rnd_q == 4'(NR));

    aes128_sub_bytes u_sub_bytes (
        .data_i(st_q),
        .data_o(sb_out)
    );

    aes128_shift_rows u_shift_rows (
        .data_i(sb_out),
        .data_o(sr_out)
    );

    aes128_mix_columns u_mix_columns (
        .data_i(sr_out),
        .data_o(mc_out)
    );

    aes128_key_step u_key_step (
        .rk_in (rk_q),
        .rcon  (rcon_cur),
        .rk_out(rk_n)
    );

    // Next-state, datapath mux and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        st_d      = st_q;
        rk_d      = rk_q;
        rnd_d     = rnd_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_ct    = '0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    st_d    = in_pt ^ in_key;
                    rk_d    = in_key;
                    rnd_d   = 4'd1;
                    state_d = StRound;
                end
            end
            StRound: begin
                busy  = 1'b1;
                // Final round skips MixColumns.
                st_d  = (last_rnd ? sr_out : mc_out) ^ rk_n;
                rk_d  = rk_n;
                rnd_d = rnd_q + 4'd1;
                if (last_rnd) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_ct    = st_q;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, cipher state, round key and round counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            st_q    <= '0;
            rk_q    <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            rnd_q   <= rnd_d;
        end
    end

endmodule

// File: tb/tb_aes128_enc_ctrl.sv
// Directed and randomised checks of aes128_enc_ctrl against an algebraic AES-128 model.
module tb_aes128_enc_ctrl;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_pt;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_ct;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] sb_tab [256];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    aes128_enc_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pt    (in_pt),
        .in_key   (in_key),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ct   (out_ct),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl1(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    // Reference cipher built from the S-box derived by field inversion plus affine map.
    function automatic logic [127:0] ref_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] k [16];
        logic [7:0] t [16];
        logic [7:0] tw [4];
        logic [7:0] rc, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127 - 8 * i -: 8];
            s[i] = pt[127 - 8 * i -: 8] ^ k[i];
        end
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            tw[0] = sb_tab[k[13]] ^ rc;
            tw[1] = sb_tab[k[14]];
            tw[2] = sb_tab[k[15]];
            tw[3] = sb_tab[k[12]];
            for (int j = 0; j < 4; j++) k[j] = k[j] ^ tw[j];
            for (int j = 4; j < 16; j++) k[j] = k[j] ^ k[j - 4];
            rc = xt(rc);
            for (int row = 0; row < 4; row++)
                for (int c = 0; c < 4; c++)
                    t[row + 4 * c] = sb_tab[s[row + 4 * ((c + row) % 4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4 * c]; a1 = t[4 * c + 1]; a2 = t[4 * c + 2]; a3 = t[4 * c + 3];
                if (r < 10) begin
                    s[4 * c]     = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4 * c + 1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4 * c + 2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4 * c + 3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    s[4 * c] = a0; s[4 * c + 1] = a1; s[4 * c + 2] = a2; s[4 * c + 3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
        end
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Offer one block at the current negedge; returns one negedge after the accept edge.
    task automatic send(input logic [127:0] key, input logic [127:0] pt);
        in_key   = key;
        in_pt    = pt;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts clock edges from the accept edge until out_valid, bounded.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        logic [7:0]   inv, xb;
        logic [127:0] held, exp_ct;
        logic [127:0] exp_q [$];
        int lat, seen, got, cyc, last_hs;
        bit acc;

        for (int x = 0; x < 256; x++) begin
            xb  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            sb_tab[x] = inv ^ rl1(inv) ^ rl1(rl1(inv)) ^ rl1(rl1(rl1(inv)))
                      ^ rl1(rl1(rl1(rl1(inv)))) ^ 8'h63;
        end

        // Reset state
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_pt = '0; in_key = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'h1);
        check("rst_out_valid", 128'(out_valid), 128'h0);
        check("rst_busy", 128'(busy), 128'h0);
        check("rst_out_ct", out_ct, 128'h0);
        check("rst_st", dut.st_q, 128'h0);
        check("rst_rk", dut.rk_q, 128'h0);
        check("rst_rnd", 128'(dut.rnd_q), 128'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 C.1 with latency
        send(C1_KEY, C1_PT);
        check("c1_busy", 128'(busy), 128'h1);
        wait_out(lat);
        check("c1_latency", 128'(lat), 128'd10);
        check("c1_ct", out_ct, C1_CT);
        @(negedge clk);
        check("c1_after_hs", 128'({in_ready, out_valid, busy}), 128'b100);

        // FIPS-197 Appendix B plus final round key
        send(B_KEY, B_PT);
        wait_out(lat);
        check("b_latency", 128'(lat), 128'd10);
        check("b_ct", out_ct, B_CT);
        check("b_rk10", dut.rk_q, B_RK10);
        @(negedge clk);

        // Backpressure: hold DONE for 20 cycles
        out_ready = 1'b0;
        send(C1_KEY, C1_PT);
        wait_out(lat);
        held = out_ct;
        check("bp_ct", held, C1_CT);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_hold", {out_valid, in_ready, out_ct}, {1'b1, 1'b0, C1_CT});
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 128'({in_ready, out_valid}), 128'b10);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("bp_single_hs", 128'(seen), 128'h0);

        // Input churn during ROUND is ignored
        send(C1_KEY, C1_PT);
        lat = 0;
        while (!out_valid && lat < 40) begin
            in_valid = 1'($urandom_range(0, 1));
            in_pt    = {$urandom, $urandom, $urandom, $urandom};
            in_key   = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("ign_latency", 128'(lat), 128'd10);
        check("ign_ct", out_ct, C1_CT);
        repeat (3) @(negedge clk);
        check("ign_no_second", 128'({in_ready, busy}), 128'b10);

        // Asynchronous reset at round 5
        send(C1_KEY, C1_PT);
        repeat (4) @(negedge clk);
        check("mid_rnd", 128'(dut.rnd_q), 128'd5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outs", {out_valid, in_ready, busy, out_ct}, {1'b0, 1'b1, 1'b0, 128'h0});
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid_no_stale", 128'(seen), 128'h0);
        send(C1_KEY, C1_PT);
        wait_out(lat);
        check("mid_next_ct", out_ct, C1_CT);
        @(negedge clk);

        // Back-to-back: 100 random blocks, in_valid held high
        got = 0; seen = 0; cyc = 0; last_hs = 0;
        in_key = {$urandom, $urandom, $urandom, $urandom};
        in_pt  = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        while (got < 100 && cyc < 5000) begin
            out_ready = (got < 50) ? 1'b1 : ($urandom_range(0, 1) == 1);
            acc = in_ready && in_valid;
            if (acc) begin
                exp_q.push_back(ref_enc(in_key, in_pt));
                seen++;
            end
            if (out_valid && out_ready) begin
                exp_ct = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                check("b2b_ct", out_ct, exp_ct);
                if (got > 0 && got < 50) check("b2b_spacing", 128'(cyc - last_hs), 128'd12);
                last_hs = cyc;
                got++;
            end
            @(negedge clk);
            cyc++;
            if (acc) begin
                in_key   = {$urandom, $urandom, $urandom, $urandom};
                in_pt    = {$urandom, $urandom, $urandom, $urandom};
                in_valid = (seen < 100);
            end
        end
        in_valid = 1'b0;
        check("b2b_count", 128'(got), 128'd100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes128_enc_ctrl.md
# aes128_enc_ctrl

Iterative AES-128 encryption sequencer. It accepts one plaintext block and one cipher key per transaction, then runs the 10-round FIPS-197 cipher at one round per clock. Each round uses the team's combinational SubBytes, ShiftRows and MixColumns blocks, plus an on-the-fly key schedule. It sits between the host-side block interface and the output buffer, and owns the round counter, state register, round-key register and both handshakes.

## Interface
- `NR`, default 10: number of rounds. Fixed for AES-128; the parameter exists for the bench only, and synthesis uses the default.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: plaintext/key offered.
- `in_ready` output 1: block can accept a new transaction.
- `in_pt` input 128: plaintext. Byte 0 is at [127:120]; bytes are column-major, so column c occupies bytes 4c..4c+3.
- `in_key` input 128: cipher key, same byte order as `in_pt`.
- `out_valid` output 1: ciphertext available.
- `out_ready` input 1: consumer accepts the ciphertext.
- `out_ct` output 128: ciphertext, same byte order.
- `busy` output 1: high in ROUND or DONE.

## Operation
- FSM states are IDLE, ROUND and DONE. Reset enters IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, load `st <= in_pt ^ in_key`, `rk <= in_key`, `rnd <= 1`, then go to ROUND.
- ROUND (`in_ready`=0):
  - Compute `rk_n = key_step(rk, rcon[rnd])`.
  - If `rnd` < NR: `st <= MixColumns(ShiftRows(SubBytes(st))) ^ rk_n`.
  - If `rnd` == NR: `st <= ShiftRows(SubBytes(st)) ^ rk_n`, with no MixColumns.
  - Update `rk <= rk_n` and `rnd <= rnd+1`.
  - Leave for DONE on the cycle `rnd` == NR.
- DONE:
  - `out_valid`=1 and `out_ct`=`st`. Both are held stable until the handshake completes.
  - On `out_ready`, go to IDLE.
- key_step, word-wise with w0 = [127:96]:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
- `rcon[1..10]` = 01,02,04,08,10,20,40,80,1b,36. All arithmetic is GF(2^8) and XOR only.
- `rnd` is a 4-bit register, with valid values 1..10 in ROUND. It never wraps: the transition to DONE happens before 11 is used. In IDLE and DONE the value of `rnd` is don't-care, but it must not reach an S-box path as an rcon index outside 1..10. The rcon lookup returns 00 for any other index.
- Inputs are sampled only on the accept edge. Changes to `in_pt`/`in_key` after acceptance have no effect.
- `in_valid` asserted in ROUND or DONE is ignored, and is not queued.
- `out_ready` asserted in IDLE or ROUND is ignored.
- Asynchronous reset at any point, including mid-round:
  - Outputs immediately return to their reset values.
  - The in-flight block is discarded and never emitted.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `busy`=0.
  - `out_ct`=128'h0.
  - `st`, `rk` and `rnd` are all zero.
- Latency: with acceptance at edge E0, `out_valid` rises after edge E0+NR, i.e. 10 cycles in ROUND.
- Throughput:
  - Best case is one block per 12 cycles: accept, 10 rounds, then DONE lasting one cycle when `out_ready`=1.
  - Back-to-back acceptance is not allowed in DONE. `in_ready` rises the cycle after the output handshake.
- Output backpressure: DONE holds indefinitely while `out_ready`=0, and `out_ct` is stable throughout.
- All outputs are registered or decoded from state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- Critical path: SubBytes → ShiftRows → MixColumns → XOR, in parallel with the key_step S-boxes. The block must close at the team's standard clock target.

## Structure
- Shared package `aes128_pkg` holds:
  - the FSM state enum {IDLE, ROUND, DONE};
  - `NR`=10;
  - the rcon constant table or function;
  - the byte-order helper (byte index → bit slice).
- Sub-module `aes128_key_step` (combinational):
  - ports `rk_in[127:0]`, `rcon[7:0]`, `rk_out[127:0]`;
  - instantiates four S-box lookups from the existing SubBytes S-box.
- The existing SubBytes, ShiftRows and MixColumns blocks are instantiated unchanged. The controller adds only the registers, FSM, mux and XORs.

## Test plan
- FIPS-197 C.1:
  - Stimulus: key `000102030405060708090a0b0c0d0e0f`, pt `00112233445566778899aabbccddeeff`, with `out_ready`=1.
  - Required: ct `69c4e0d86a7b0430d8cdb78070b4c55a`, with `out_valid` exactly 10 cycles after accept.
- FIPS-197 App. B:
  - Stimulus: key `2b7e151628aed2a6abf7158809cf4f3c`, pt `3243f6a8885a308d313198a2e0370734`.
  - Required: ct `3925841d02dc09fbdc118597196a0b32`.
  - Also check internal `rk` after round 10 = `d014f9a8c9ee2589e13f0cc8b6630ca6`.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 20 cycles after `out_valid`.
  - Required: `out_ct` stable, `in_ready`=0 throughout, and a single handshake on release.
- Ignored inputs:
  - Stimulus: toggle `in_valid`, `in_pt` and `in_key` during ROUND.
  - Required: result unchanged (C.1 vector), and no second transaction starts.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 at round 5, then release.
  - Required: `out_valid`=0, `in_ready`=1, `out_ct`=0, and no stale ciphertext emitted. The next C.1 transaction gives the correct ct.
- Back-to-back:
  - Stimulus: 100 random key/pt pairs with `in_valid` held high and random `out_ready`.
  - Required: every ct matches the reference model, in order, with 12-cycle spacing when `out_ready`=1.
